hdr_fifo: RTL and testbench
===========================

HDR_FIFO -- requirements
Module: hdr_fifo

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the entry width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set depth DEPTH = 2^ADDR_W entries.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, SHALL set the almost_full threshold in entries.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  synchronous discard of all stored entries.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  FIFO can accept a write this cycle.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 rd_valid  out  1  rd_data holds the head entry.
REQ-011 rd_ready  in  1  consumer takes the head entry.
REQ-012 rd_data  out  DATA_W  head entry, first-word-fall-through.
REQ-013 count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-014 almost_full  out  1  count >= AFULL_LVL.
REQ-015 ovf_err  out  1  sticky: wr_valid seen while wr_ready=0.

Function
REQ-016 A write SHALL occur when wr_valid & wr_ready; a read SHALL occur when rd_valid & rd_ready.
REQ-017 wr_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on rd_ready.
REQ-018 rd_valid SHALL equal (count != 0).
REQ-019 Write and read pointers SHALL be ADDR_W+1 bits; low ADDR_W bits address storage; MSB is the wrap bit; both SHALL wrap from 2^(ADDR_W+1)-1 to 0.
REQ-020 count SHALL be computed as wr_ptr - rd_ptr modulo 2^(ADDR_W+1); full = count==DEPTH, empty = count==0.
REQ-021 Write latency: data written at edge N SHALL appear on rd_data with rd_valid=1 after edge N if the FIFO was empty; no same-cycle bypass from wr_data to rd_data.
REQ-022 rd_data SHALL be an asynchronous read of storage at rd_ptr; when rd_valid=0, rd_data is don't-care.
REQ-023 Simultaneous write and read SHALL leave count unchanged and advance both pointers, including when count==1.
REQ-024 When full, a read with wr_valid=1 in the same cycle SHALL NOT write; wr_ready rises the cycle after the read.
REQ-025 wr_valid while full SHALL be dropped, SHALL NOT alter storage or pointers, and SHALL set ovf_err.
REQ-026 ovf_err SHALL clear only on rst, not on flush.
REQ-027 flush SHALL zero both pointers at the next edge, takes priority over any same-cycle read or write, and the write in that cycle SHALL be discarded.
REQ-028 Storage contents SHALL NOT be cleared by rst or flush; only pointers are cleared.
REQ-029 almost_full SHALL be a registered output updated with count, consistent with count in the same cycle.

Reset
REQ-030 On rst: wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, wr_ready=1, almost_full=0, ovf_err=0; rst overrides flush, writes and reads in the same cycle.
REQ-031 A rst asserted mid-burst SHALL discard all entries; the first write after rst deasserts SHALL be read back as the first entry.

Structure
REQ-032 Shared package/include SHALL hold default DATA_W, ADDR_W, AFULL_LVL and the pointer-width derivation ADDR_W+1.
REQ-033 Storage SHALL be one sub-module hdr_dpram: parametrised DATA_W x 2^ADDR_W, one synchronous write port, one asynchronous read port, mapping to distributed RAM.
REQ-034 hdr_fifo SHALL hold only pointers, flags and the ovf_err register; no storage outside hdr_dpram.

Verification (DATA_W=32, ADDR_W=4, AFULL_LVL=14)
REQ-035 Reset then write 0x00000001..0x00000010 with rd_ready=0 -> count 16, wr_ready=0, almost_full=1 from count 14; then read all -> rd_data 0x1..0x10 in order, count 0, rd_valid=0.
REQ-036 Single write 0xDEADBEEF into empty FIFO -> rd_valid=0 same cycle, rd_valid=1 and rd_data=0xDEADBEEF the next cycle.
REQ-037 Fill to 16, hold wr_valid=1 with wr_data=0xBAD0BAD0 and rd_ready=1 for one cycle -> no write, count 15, ovf_err=1, 0xBAD0BAD0 never read.
REQ-038 Continuous write+read for 40 cycles at count=3 -> count stays 3, pointers wrap twice, output order matches input order.
REQ-039 Fill to 9, assert flush with wr_valid=1 -> count 0 next cycle, rd_valid=0, ovf_err unchanged; subsequent write 0x55 read first.
REQ-040 Assert rst at count 7 with wr_valid=1 and rd_ready=1 -> all outputs at REQ-030 values next cycle; ovf_err cleared.

Source files
------------

// File: rtl/hdr_fifo_pkg.sv
// Shared defaults for the header FIFO: entry width, depth exponent,
// almost-full threshold and the pointer-width derivation.
package hdr_fifo_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AFULL_LVL = (1 << DEF_ADDR_W) - 2;

  // One extra wrap bit distinguishes full from empty when the low bits match.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/hdr_dpram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Intentionally unreset so it maps onto distributed RAM.
module hdr_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hdr_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers, registered almost_full,
// synchronous flush and a sticky overflow flag. Storage lives in hdr_dpram.
module hdr_fifo
  import hdr_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_LVL = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              ovf_err
);

  localparam int PTR_W = ptr_w(ADDR_W);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(1 << ADDR_W);
  localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_LVL);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0] count_nxt;
  logic             do_wr, do_rd;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; wr_ready and rd_valid come from registered pointers only, so
  // neither depends combinationally on the other side's request.
  assign count    = wr_ptr - rd_ptr;
  assign wr_ready = (count != DEPTH_CNT);
  assign rd_valid = (count != '0);

  // Writes are suppressed during flush/rst so a discarded word never touches storage.
  assign do_wr = wr_valid & wr_ready & ~flush & ~rst;
  assign do_rd = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (do_wr) wr_ptr_nxt = wr_ptr + 1'b1;
      if (do_rd) rd_ptr_nxt = rd_ptr + 1'b1;
    end
  end

  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      almost_full <= (count_nxt >= AFULL_CNT);
      ovf_err     <= ovf_err | (wr_valid & ~wr_ready);
    end
  end

  hdr_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_hdr_fifo.sv
// Bench for hdr_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hdr_fifo;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;

  logic              clk;
  logic              rst, flush, wr_valid, rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, rd_valid, almost_full, ovf_err;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf = 1'b0;
  logic              chk_en  = 1'b0;

  hdr_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .ovf_err     (ovf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: occupancy is the queue, transfers follow the handshake rules
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      chk_en  = 1'b1;
    end else begin
      automatic bit full  = (exp_q.size() == DEPTH);
      automatic bit empty = (exp_q.size() == 0);
      if (wr_valid && full) exp_ovf = 1'b1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (rd_ready && !empty) void'(exp_q.pop_front());
        if (wr_valid && !full) exp_q.push_back(wr_data);
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() != DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
      chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
      if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
    end
  end

  // driver: apply inputs at a negedge, return at the next negedge
  task automatic step(input logic wv, input logic [31:0] wd, input logic rr,
                      input logic fl, input logic rs);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    chk("reset_count", 32'(count), 0);
    chk("reset_wr_ready", 32'(wr_ready), 1);
    chk("reset_rd_valid", 32'(rd_valid), 0);

    // fill 1..16 then drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1, 32'(i), 0, 0, 0);
      if (i == 13) chk("afull_at_13", 32'(almost_full), 0);
      if (i == 14) chk("afull_at_14", 32'(almost_full), 1);
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_wr_ready", 32'(wr_ready), 0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", rd_data, 32'(i));
      step(0, 0, 1, 0, 0);
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_rd_valid", 32'(rd_valid), 0);

    // single write latency
    chk("lat_rd_valid_before", 32'(rd_valid), 0);
    step(1, 32'hDEADBEEF, 0, 0, 0);
    chk("lat_rd_valid_after", 32'(rd_valid), 1);
    chk("lat_rd_data", rd_data, 32'hDEADBEEF);
    step(0, 0, 1, 0, 0);

    // overflow while full with a simultaneous read
    for (int i = 0; i < 16; i++) step(1, 32'(32'h100 + i), 0, 0, 0);
    step(1, 32'hBAD0BAD0, 1, 0, 0);
    chk("ovf_count", 32'(count), 15);
    chk("ovf_flag", 32'(ovf_err), 1);
    for (int i = 0; i < 15; i++) begin
      chk("ovf_no_bad", 32'(rd_data != 32'hBAD0BAD0), 1);
      step(0, 0, 1, 0, 0);
    end

    // flush at 9 with a write in the same cycle
    for (int i = 0; i < 9; i++) step(1, 32'(32'h200 + i), 0, 0, 0);
    step(1, 32'h77, 0, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_ovf_kept", 32'(ovf_err), 1);
    step(1, 32'h55, 0, 0, 0);
    step(1, 32'h66, 0, 0, 0);
    chk("flush_first", rd_data, 32'h55);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // streaming at occupancy 3 with pointer wrap
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h300 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 32'(32'h400 + i), 1, 0, 0);
    chk("stream_count", 32'(count), 3);
    chk("stream_head", rd_data, 32'h425);

    // reset mid-burst at count 7 with ovf set
    for (int i = 0; i < 14; i++) step(1, 32'(32'h500 + i), 0, 0, 0);
    step(1, 32'h5FF, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);
    chk("pre_rst_count", 32'(count), 7);
    step(1, 32'h600, 1, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    step(1, 32'hA1, 0, 0, 0);
    chk("post_rst_first", rd_data, 32'hA1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      automatic int wbias = (i / 500) % 3;
      step(logic'($urandom_range(0, 3) < 1 + wbias), $urandom,
           logic'($urandom_range(0, 3) < 3 - wbias),
           logic'($urandom_range(0, 99) == 0),
           logic'($urandom_range(0, 399) == 0));
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
